regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor of the ID-stage register file.
- Configurable data width, register count and number of read ports.
- Optional hardwired zero register and write-to-read bypass, so the WB→ID same-cycle hazard is handled without a negedge write.
- Adds a handshaked sequential dump port that streams every register to the debug unit (UART dumper) while the pipeline keeps running.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; NUM_REGS = 2**ADDR_W.
- NRD, 2: number of combinational read ports.
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read and dump addresses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- dbg_start  in  1  single-cycle pulse that starts a dump.
- dbg_busy  out  1  dump in progress.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  consumer accepts beat.
- dbg_addr  out  ADDR_W  register index of the current beat.
- dbg_data  out  DATA_W  register content of the current beat.
- dbg_last  out  1  current beat is register NUM_REGS-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear to 0; dump FSM returns to IDLE; pointer clears to 0.
  - dbg_busy=0, dbg_valid=0, dbg_last=0, dbg_addr=0.
  - dbg_data=0 and rd_data=0 while reset is held.
  - Deassertion is sampled on the next rising clk.
- Write:
  - On the rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency):
  - rd_data[k] = reg[rd_addr[k]].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr[k] and the write is not dropped, rd_data[k] = wr_data.
  - If ZERO_REG=1 and rd_addr[k]=0, rd_data[k] = 0, regardless of bypass.
  - If BYPASS=0, a read returns the new value only on the cycle after the write edge.
- Dump FSM, states IDLE and SCAN:
  - IDLE: dbg_valid=0, dbg_busy=0.
    - dbg_start=1 → SCAN with ptr=0.
  - SCAN: dbg_busy=1, dbg_valid=1, dbg_addr=ptr.
    - dbg_data follows the read-port rules for ptr: current content, same-cycle bypass if BYPASS=1, and 0 for ptr=0 when ZERO_REG=1.
    - dbg_last = (ptr == NUM_REGS-1).
  - Beat transfer: dbg_valid & dbg_ready on a rising edge.
    - Not last: ptr increments.
    - Last: → IDLE, ptr cleared.
  - Stall: dbg_ready=0 holds ptr and dbg_addr. dbg_data may change if reg[ptr] is written during the stall; the consumer takes the value present at the transfer edge.
  - dbg_start while in SCAN is ignored; there is no restart.
  - dbg_start in the same cycle the last beat transfers is ignored; the FSM goes to IDLE.
  - Exactly NUM_REGS beats per dump, addresses 0..NUM_REGS-1 in order, no gaps or repeats.
  - Writes to already-dumped registers are not re-sent.
- Simultaneous events:
  - Write and dump transfer of the same register in one cycle: with BYPASS=1 the beat carries wr_data; with BYPASS=0 it carries the old value.
  - The write always lands.
- Reset mid-scan aborts the dump immediately: dbg_valid drops asynchronously and registers clear.
- Widths: no arithmetic except ptr+1, which is ADDR_W wide; wrap is prevented by the last-beat exit.

Test Plan:
- Reset/zero: hold reset=0, then release. Write 0xDEADBEEF to r0, then read r0 → 0. Write 0x12345678 to r5; next cycle rd_addr[0]=5 → 0x12345678.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr[1]=7 in the same cycle → rd_data[1]=0xA5A5A5A5 with BYPASS=1; old value 0 with BYPASS=0.
- Full dump: preload r[i]=i*0x11, pulse dbg_start, dbg_ready=1 → 32 beats, addr 0..31, data i*0x11 (r0 = 0), dbg_last only on beat 31, dbg_busy low the cycle after.
- Backpressure: during a dump toggle dbg_ready 1,0,0,1 and write r3=0xCAFE while stalled at ptr=3 → no skipped or duplicated addresses, beat 3 = 0xCAFE, dbg_start pulses mid-scan ignored.
- Reset mid-scan: assert reset at beat 10 → dbg_valid=0 and dbg_busy=0 immediately, all reads 0. Restart the dump → begins at addr 0.
- Parametrised build DATA_W=16, ADDR_W=3, NRD=3, ZERO_REG=0: write r0=0xBEEF, read on all three ports → 0xBEEF. Dump → 8 beats, last flagged on addr 7.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port register file with an optional hardwired
//            zero register, an optional write-to-read bypass and a handshaked
//            sequential dump port that streams every register to a debug
//            consumer while normal reads and writes continue.
// Ports    : clk        - clock, all state changes on the rising edge
//            reset      - asynchronous active-low reset
//            rd_addr    - NRD packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//            rd_data    - NRD packed read data      (port k at [k*DATA_W +: DATA_W])
//            wr_en      - write enable
//            wr_addr    - write address
//            wr_data    - write data
//            dbg_start  - one-cycle pulse that starts a dump
//            dbg_busy   - dump in progress
//            dbg_valid  - dump beat valid
//            dbg_ready  - consumer accepts the current beat
//            dbg_addr   - register index of the current beat
//            dbg_data   - register content of the current beat
//            dbg_last   - current beat is the highest register
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  dbg_start,
  output logic                  dbg_busy,
  output logic                  dbg_valid,
  input  logic                  dbg_ready,
  output logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  dbg_last
);

  localparam int              c_num_regs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_regs [c_num_regs];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_wr_act;
  logic              w_scan;

  // A write to the zero register is discarded, and must not be forwarded.
  assign w_wr_act = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_act) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Shared read rule for the read ports and the dump port: current content,
  // overridden by a same-cycle write when bypassing, and the zero register
  // overrides everything.
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_regs[a];
    if ((BYPASS != 0) && w_wr_act && (wr_addr == a)) begin
      v = wr_data;
    end
    if ((ZERO_REG != 0) && (a == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  // Outputs are gated while reset is held so a bypassed write cannot leak out.
  for (genvar k = 0; k < NRD; k++) begin : g_rd_port
    assign rd_data[k*DATA_W +: DATA_W] =
      reset ? read_val(rd_addr[k*ADDR_W +: ADDR_W]) : '0;
  end

  // Dump FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (dbg_start) begin
          w_state_nxt = S_SCAN;
          w_ptr_nxt   = '0;
        end
      end
      S_SCAN: begin
        // dbg_start is deliberately ignored here: no restart mid-scan.
        if (dbg_ready) begin
          if (r_ptr == c_last_idx) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + c_one;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // The state flop clears asynchronously, so valid/busy drop with reset.
  assign w_scan    = (r_state == S_SCAN);
  assign dbg_busy  = w_scan;
  assign dbg_valid = w_scan;
  assign dbg_addr  = r_ptr;
  assign dbg_last  = w_scan && (r_ptr == c_last_idx);
  assign dbg_data  = (w_scan && reset) ? read_val(r_ptr) : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp. Three instances:
//            default build, a BYPASS=0 build sharing its stimulus, and a
//            16-bit / 8-register / 3-read-port build without a zero register.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic        clk;
  logic        reset;

  // Default build and BYPASS=0 build share their inputs.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] nb_rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dbg_start;
  logic        dbg_ready;
  logic        dbg_busy,  nb_dbg_busy;
  logic        dbg_valid, nb_dbg_valid;
  logic [4:0]  dbg_addr,  nb_dbg_addr;
  logic [31:0] dbg_data,  nb_dbg_data;
  logic        dbg_last,  nb_dbg_last;

  // Small build
  logic [8:0]  p_rd_addr;
  logic [47:0] p_rd_data;
  logic        p_wr_en;
  logic [2:0]  p_wr_addr;
  logic [15:0] p_wr_data;
  logic        p_dbg_start;
  logic        p_dbg_ready;
  logic        p_dbg_busy;
  logic        p_dbg_valid;
  logic [2:0]  p_dbg_addr;
  logic [15:0] p_dbg_data;
  logic        p_dbg_last;

  int vectors;
  int miscompares;
  logic [31:0] model [32];

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(dbg_start), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_last(dbg_last)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_start(dbg_start), .dbg_busy(nb_dbg_busy), .dbg_valid(nb_dbg_valid),
    .dbg_ready(dbg_ready), .dbg_addr(nb_dbg_addr), .dbg_data(nb_dbg_data),
    .dbg_last(nb_dbg_last)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(3), .ZERO_REG(0)) dut_p (
    .clk(clk), .reset(reset), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .dbg_start(p_dbg_start), .dbg_busy(p_dbg_busy), .dbg_valid(p_dbg_valid),
    .dbg_ready(p_dbg_ready), .dbg_addr(p_dbg_addr), .dbg_data(p_dbg_data),
    .dbg_last(p_dbg_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h1111_2222;
    rd_addr = {5'd5, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0);
    end
    vectors++;
    if ({dbg_busy, dbg_valid, dbg_last} !== 3'b000 || dbg_addr !== 5'd0 || dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dbg: busy/valid/last=%b addr=%0d data=%h expected 000/0/0",
               {dbg_busy, dbg_valid, dbg_last}, dbg_addr, dbg_data);
    end
    vectors++;
    if (nb_rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_nb_rd_data: got %h expected %h", nb_rd_data, 64'h0);
    end
    wr_en = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    vectors++;
    if (rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_write_blocked: got %h expected %h", rd_data, 64'h0);
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_zero_reg();
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd0, 5'd0};
    #1;
    vectors++;
    if (rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL zero_same_cycle: got %h expected %h", rd_data, 64'h0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    vectors++;
    if (rd_data !== 64'h0 || nb_rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL zero_after_write: got %h / %h expected 0", rd_data, nb_rd_data);
    end
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h1234_5678;
    tick();
    wr_en   = 1'b0;
    rd_addr = {5'd0, 5'd5};
    #1;
    vectors++;
    if (rd_data[31:0] !== 32'h1234_5678 || nb_rd_data[31:0] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_r5: got %h / %h expected 12345678", rd_data[31:0], nb_rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5_A5A5;
    rd_addr = {5'd7, 5'd0};
    #1;
    vectors++;
    if (rd_data[63:32] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_on: got %h expected a5a5a5a5", rd_data[63:32]);
    end
    vectors++;
    if (nb_rd_data[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_off_same_cycle: got %h expected 0", nb_rd_data[63:32]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    vectors++;
    if (nb_rd_data[63:32] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_off_next_cycle: got %h expected a5a5a5a5", nb_rd_data[63:32]);
    end
  endtask

  task automatic test_full_dump();
    logic [31:0] exp;
    for (int i = 1; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = i * 32'h11;
      tick();
    end
    wr_en     = 1'b0;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    dbg_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp = (i == 0) ? 32'h0 : i * 32'h11;
      vectors++;
      if (dbg_valid !== 1'b1 || dbg_addr !== 5'(i) || dbg_data !== exp || dbg_last !== (i == 31)) begin
        miscompares++;
        $display("FAIL dump_beat%0d: valid=%b addr=%0d data=%h last=%b expected 1/%0d/%h/%b",
                 i, dbg_valid, dbg_addr, dbg_data, dbg_last, i, exp, (i == 31));
      end
      @(posedge clk);
      #1;
    end
    dbg_ready = 1'b0;
    #1;
    vectors++;
    if (dbg_busy !== 1'b0 || dbg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_end_idle: busy=%b valid=%b expected 0/0", dbg_busy, dbg_valid);
    end
    for (int i = 0; i < 32; i++) model[i] = (i == 0) ? 32'h0 : i * 32'h11;
  endtask

  task automatic test_back_pressure();
    bit          ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          exp_ptr;
    int          beats;
    int          cyc;
    bit          wrote;
    logic [31:0] exp;
    logic [31:0] beat3;
    exp_ptr = 0;
    beats   = 0;
    cyc     = 0;
    wrote   = 1'b0;
    beat3   = 32'hX;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    while (beats < 32 && cyc < 200) begin
      dbg_ready = ready_pat[cyc % 4];
      dbg_start = (cyc == 5 || cyc == 20);
      wr_en     = 1'b0;
      if (exp_ptr == 3 && !dbg_ready && !wrote) begin
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h0000_CAFE;
        wrote   = 1'b1;
      end
      #1;
      exp = model[exp_ptr];
      if (wr_en && wr_addr == 5'(exp_ptr)) exp = wr_data;
      vectors++;
      if (dbg_valid !== 1'b1 || dbg_addr !== 5'(exp_ptr)) begin
        miscompares++;
        $display("FAIL bp_addr_cyc%0d: valid=%b addr=%0d expected 1/%0d", cyc, dbg_valid, dbg_addr, exp_ptr);
      end
      if (dbg_ready) begin
        vectors++;
        if (dbg_data !== exp) begin
          miscompares++;
          $display("FAIL bp_data_beat%0d: got %h expected %h", exp_ptr, dbg_data, exp);
        end
        if (exp_ptr == 3) beat3 = dbg_data;
      end
      @(posedge clk);
      #1;
      if (wr_en) model[wr_addr] = wr_data;
      if (dbg_ready) begin
        beats++;
        exp_ptr++;
      end
      cyc++;
    end
    dbg_ready = 1'b0;
    dbg_start = 1'b0;
    wr_en     = 1'b0;
    #1;
    vectors++;
    if (beats !== 32) begin
      miscompares++;
      $display("FAIL bp_beat_count: got %0d expected 32", beats);
    end
    vectors++;
    if (beat3 !== 32'h0000_CAFE) begin
      miscompares++;
      $display("FAIL bp_beat3_stall_write: got %h expected 0000cafe", beat3);
    end
    vectors++;
    if (dbg_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end_idle: busy=%b expected 0", dbg_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    dbg_ready = 1'b1;
    repeat (10) tick();
    #1;
    vectors++;
    if (dbg_addr !== 5'd10 || dbg_data !== 32'h0000_00AA) begin
      miscompares++;
      $display("FAIL mid_pre_reset: addr=%0d data=%h expected 10/000000aa", dbg_addr, dbg_data);
    end
    reset   = 1'b0;
    rd_addr = {5'd10, 5'd5};
    #1;
    vectors++;
    if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0 || dbg_last !== 1'b0 || dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset_dbg: valid=%b busy=%b last=%b data=%h expected 0/0/0/0",
               dbg_valid, dbg_busy, dbg_last, dbg_data);
    end
    vectors++;
    if (rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset_rd: got %h expected 0", rd_data);
    end
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (rd_data !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset_cleared: got %h expected 0", rd_data);
    end
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    #1;
    vectors++;
    if (dbg_valid !== 1'b1 || dbg_addr !== 5'd0 || dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL restart_beat0: valid=%b addr=%0d data=%h expected 1/0/0", dbg_valid, dbg_addr, dbg_data);
    end
    tick();
    #1;
    vectors++;
    if (dbg_addr !== 5'd1 || dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL restart_beat1: addr=%0d data=%h expected 1/0", dbg_addr, dbg_data);
    end
    for (int i = 0; i < 40 && dbg_busy; i++) tick();
    dbg_ready = 1'b0;
    #1;
    vectors++;
    if (dbg_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_complete: busy=%b expected 0 within budget", dbg_busy);
    end
  endtask

  task automatic test_param_build();
    p_wr_en   = 1'b1;
    p_wr_addr = 3'd0;
    p_wr_data = 16'hBEEF;
    p_rd_addr = {3'd0, 3'd0, 3'd0};
    #1;
    vectors++;
    if (p_rd_data !== {3{16'hBEEF}}) begin
      miscompares++;
      $display("FAIL param_bypass_r0: got %h expected beefbeefbeef", p_rd_data);
    end
    tick();
    p_wr_en = 1'b0;
    #1;
    vectors++;
    if (p_rd_data !== {3{16'hBEEF}}) begin
      miscompares++;
      $display("FAIL param_read_r0: got %h expected beefbeefbeef", p_rd_data);
    end
    p_dbg_start = 1'b1;
    tick();
    p_dbg_start = 1'b0;
    p_dbg_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (p_dbg_valid !== 1'b1 || p_dbg_addr !== 3'(i) || p_dbg_last !== (i == 7) ||
          p_dbg_data !== ((i == 0) ? 16'hBEEF : 16'h0)) begin
        miscompares++;
        $display("FAIL param_dump_beat%0d: valid=%b addr=%0d last=%b data=%h expected 1/%0d/%b/%h",
                 i, p_dbg_valid, p_dbg_addr, p_dbg_last, p_dbg_data, i, (i == 7),
                 ((i == 0) ? 16'hBEEF : 16'h0));
      end
      @(posedge clk);
      #1;
    end
    p_dbg_ready = 1'b0;
    #1;
    vectors++;
    if (p_dbg_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL param_dump_end: busy=%b expected 0", p_dbg_busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    dbg_start   = 1'b0;
    dbg_ready   = 1'b0;
    p_rd_addr   = '0;
    p_wr_en     = 1'b0;
    p_wr_addr   = '0;
    p_wr_data   = '0;
    p_dbg_start = 1'b0;
    p_dbg_ready = 1'b0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_full_dump();
    test_back_pressure();
    test_reset_mid_scan();
    test_param_build();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
